// File: rtl/npc_seq.sv
// -----------------------------------------------------------------------------
// npc_seq -- sequential next-PC unit with stall and return-address stack.
//
// Holds the architectural PC and picks the next fetch address with the
// priority jr > taken branch > jump > pc+4. A small circular return-address
// stack (RAS) records jal return addresses. A jr-ret pops the stack, and any
// disagreement with the register target is reported one cycle later on
// ras_mispredict. The RAS never redirects fetch; jr always uses jr_addr.
//
// Parameters
//   ADDR_W    PC width, 28..32. PC bits [ADDR_W-1:28] form the jump region.
//   RESET_PC  PC value after reset, truncated to ADDR_W.
//   RAS_DEPTH RAS entries, a power of two in 2..16.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   stall           freeze PC, RAS and ras_mispredict; other inputs ignored
//   branch          conditional branch, branch_ne selects bne (1) or beq (0)
//   zero            ALU zero flag
//   jump, link      j-type jump, link turns it into jal (push pc4)
//   jr, ret         register jump, ret turns it into jr $ra (pop RAS)
//   jr_addr         register jump target
//   target          26-bit jump field
//   immediate       16-bit branch offset field (in words)
//   pc, pc4         current PC and PC+4
//   ras_empty/full  RAS occupancy flags
//   ras_mispredict  ret popped a wrong or missing entry on the last active cycle
// -----------------------------------------------------------------------------
module npc_seq #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic              zero,
    input  logic              jump,
    input  logic              link,
    input  logic              jr,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic [25:0]       target,
    input  logic [15:0]       immediate,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_mispredict
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_count;
    logic              r_mispredict;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_top_entry;
    logic [PTR_W-1:0]  w_top_inc;
    logic              w_taken;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;

    assign w_pc4        = r_pc + PC_STEP;
    // Word offset: sign-extend, then shift left by two; wraps modulo 2^ADDR_W.
    assign w_branch_tgt = w_pc4 + {{(ADDR_W-18){immediate[15]}}, immediate, 2'b00};
    assign w_taken      = branch & (branch_ne ? ~zero : zero);

    generate
        if (ADDR_W > 28) begin : g_region
            assign w_jump_tgt = {r_pc[ADDR_W-1:28], target, 2'b00};
        end else begin : g_no_region
            assign w_jump_tgt = {target, 2'b00};
        end
    endgenerate

    // A jal pushes only when it actually selects the next PC. A jr or a taken
    // branch in the same cycle suppresses the push.
    assign w_push      = ~stall & ~jr & ~w_taken & jump & link;
    assign w_pop       = ~stall & jr & ret;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_top_entry = r_ras[r_top];
    // RAS_DEPTH is a power of two, so the pointer wraps naturally.
    assign w_top_inc   = r_top + PTR_W'(1);

    // NOTE: every path assigns w_next_pc through the default first, so no latch is inferred.
    always_comb begin
        w_next_pc = w_pc4;
        if (jr) begin
            w_next_pc = jr_addr;
        end else if (w_taken) begin
            w_next_pc = w_branch_tgt;
        end else if (jump) begin
            w_next_pc = w_jump_tgt;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC[ADDR_W-1:0];
            r_top        <= '0;
            r_count      <= '0;
            r_mispredict <= 1'b0;
        end else if (!stall) begin
            r_pc         <= w_next_pc;
            // An empty pop counts as a mispredict, as does a popped value that differs from jr_addr.
            r_mispredict <= w_pop & (w_empty | (w_top_entry != jr_addr));
            if (w_push) begin
                r_top <= w_top_inc;
                // When full, the oldest entry is overwritten and the count saturates.
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop && !w_empty) begin
                r_top   <= r_top - PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // NOTE: RAS storage has no reset; the count marks which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_top_inc] <= w_pc4;
        end
    end

    assign pc             = r_pc;
    assign pc4            = w_pc4;
    assign ras_empty      = w_empty;
    assign ras_full       = w_full;
    assign ras_mispredict = r_mispredict;

endmodule

// File: tb/tb_npc_seq.sv
// -----------------------------------------------------------------------------
// tb_npc_seq -- self-checking bench for npc_seq.
//
// Instance 0: ADDR_W=32, RESET_PC=0x0040_0000, RAS_DEPTH=4.
// Instance 1: ADDR_W=28, RESET_PC=0, RAS_DEPTH=2.
// Both instances share the same stimulus. A behavioural model holds the PC as
// plain arithmetic and each RAS as a bounded queue, and one compare process
// checks all outputs against it on every falling edge outside reset.
// Directed sections add literal expectations; a random section follows them.
// -----------------------------------------------------------------------------
module tb_npc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, branch = 1'b0, branch_ne = 1'b0, zero = 1'b0;
    logic        jump = 1'b0, link = 1'b0, jr = 1'b0, ret = 1'b0;
    logic [31:0] jr_addr = '0;
    logic [25:0] target = '0;
    logic [15:0] immediate = '0;

    logic [31:0] pc0, pc4_0;
    logic [27:0] pc1, pc4_1;
    logic        empty0, full0, mis0, empty1, full1, mis1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model state
    logic [31:0] m_pc  [2];
    logic        m_mis [2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    npc_seq #(.ADDR_W(32), .RESET_PC(32'h0040_0000), .RAS_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_ne(branch_ne),
        .zero(zero), .jump(jump), .link(link), .jr(jr), .ret(ret),
        .jr_addr(jr_addr), .target(target), .immediate(immediate),
        .pc(pc0), .pc4(pc4_0), .ras_empty(empty0), .ras_full(full0),
        .ras_mispredict(mis0)
    );

    npc_seq #(.ADDR_W(28), .RESET_PC(32'h0000_0000), .RAS_DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_ne(branch_ne),
        .zero(zero), .jump(jump), .link(link), .jr(jr), .ret(ret),
        .jr_addr(jr_addr[27:0]), .target(target), .immediate(immediate),
        .pc(pc1), .pc4(pc4_1), .ras_empty(empty1), .ras_full(full1),
        .ras_mispredict(mis1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int ras_size(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    task automatic ras_push(input int idx, input logic [31:0] v);
        if (idx == 0) begin
            q0.push_back(v);
            if (q0.size() > 4) void'(q0.pop_front());
        end else begin
            q1.push_back(v);
            if (q1.size() > 2) void'(q1.pop_front());
        end
    endtask

    task automatic ras_pop(input int idx, output logic [31:0] v);
        if (idx == 0) v = q0.pop_back();
        else          v = q1.pop_back();
    endtask

    task automatic model_step(input int idx);
        logic [31:0] mask, cur, nxt_pc, nxt_pc4, popped, offs;
        logic        mis, taken;
        mask = (idx == 0) ? 32'hFFFF_FFFF : 32'h0FFF_FFFF;
        if (stall) return;
        cur     = m_pc[idx];
        nxt_pc4 = (cur + 32'd4) & mask;
        offs    = {{14{immediate[15]}}, immediate, 2'b00};
        taken   = branch && (branch_ne ? !zero : zero);
        mis     = 1'b0;
        if (jr) begin
            nxt_pc = jr_addr & mask;
            if (ret) begin
                if (ras_size(idx) == 0) begin
                    mis = 1'b1;
                end else begin
                    ras_pop(idx, popped);
                    mis = (popped != nxt_pc);
                end
            end
        end else if (taken) begin
            nxt_pc = (nxt_pc4 + offs) & mask;
        end else if (jump) begin
            nxt_pc = (cur & mask & 32'hF000_0000) | {4'b0, target, 2'b00};
            if (link) ras_push(idx, nxt_pc4);
        end else begin
            nxt_pc = nxt_pc4;
        end
        m_pc[idx]  = nxt_pc;
        m_mis[idx] = mis;
    endtask

    task automatic model_reset();
        m_pc[0]  = 32'h0040_0000;
        m_pc[1]  = 32'h0;
        m_mis[0] = 1'b0;
        m_mis[1] = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("pc0",    pc0,    m_pc[0]);
            check("pc4_0",  pc4_0,  m_pc[0] + 32'd4);
            check("empty0", {31'b0, empty0}, {31'b0, q0.size() == 0});
            check("full0",  {31'b0, full0},  {31'b0, q0.size() == 4});
            check("mis0",   {31'b0, mis0},   {31'b0, m_mis[0]});
            check("pc1",    {4'b0, pc1},     m_pc[1]);
            check("pc4_1",  {4'b0, pc4_1},   (m_pc[1] + 32'd4) & 32'h0FFF_FFFF);
            check("empty1", {31'b0, empty1}, {31'b0, q1.size() == 0});
            check("full1",  {31'b0, full1},  {31'b0, q1.size() == 2});
            check("mis1",   {31'b0, mis1},   {31'b0, m_mis[1]});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; asserts reset asynchronously and
    // releases it well before the next rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_pc0",    pc0, 32'h0040_0000);
        check("rst_pc1",    {4'b0, pc1}, 32'h0);
        check("rst_empty0", {31'b0, empty0}, 32'd1);
        check("rst_full0",  {31'b0, full0}, 32'd0);
        check("rst_mis0",   {31'b0, mis0}, 32'd0);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic s, input logic b, input logic bne, input logic z,
                        input logic j, input logic l, input logic r, input logic rt,
                        input logic [31:0] ja, input logic [25:0] t, input logic [15:0] im);
        stall = s; branch = b; branch_ne = bne; zero = z;
        jump = j; link = l; jr = r; ret = rt;
        jr_addr = ja; target = t; immediate = im;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 16'h0);
    endtask

    task automatic go_jr(input logic [31:0] a);
        step(0, 0, 0, 0, 0, 0, 1, 0, a, 26'h0, 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;

        // Reset then sequential fetch, with a reset pulse mid-run
        idle(); idle();
        do_reset();
        idle(); check("seq1", pc0, 32'h0040_0004);
        idle(); check("seq2", pc0, 32'h0040_0008);
        idle(); check("seq3", pc0, 32'h0040_000C);

        // Branches
        go_jr(32'h100);
        step(0, 1, 0, 1, 0, 0, 0, 0, 32'h0, 26'h0, 16'hFFFF);
        check("beq_back", pc0, 32'h100);
        step(0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 26'h0, 16'h0003);
        check("bne_taken", pc0, 32'h110);
        step(0, 1, 1, 1, 0, 0, 0, 0, 32'h0, 26'h0, 16'hFFFF);
        check("bne_not_taken", pc0, 32'h114);

        // Jump and priority
        go_jr(32'hA000_0000);
        step(0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 26'h0000010, 16'h0);
        check("jump", pc0, 32'hA000_0040);
        go_jr(32'hA000_0000);
        step(0, 0, 0, 0, 1, 1, 1, 0, 32'h1234, 26'h0000010, 16'h0);
        check("jr_prio", pc0, 32'h1234);
        check("jr_no_push", {31'b0, empty0}, 32'd1);

        // RAS depth: five jal pushes, return addresses 0x1238,0x404,0x804,0xC04,0x1004
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 26'(i * 32'h100), 16'h0);
            if (i == 4) check("ras_full4", {31'b0, full0}, 32'd1);
        end
        check("ras_full5", {31'b0, full0}, 32'd1);
        check("jal_pc", pc0, 32'h1400);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 1, 32'h1004 - 32'(i) * 32'h400, 26'h0, 16'h0);
            check("ret_pc", pc0, 32'h1004 - 32'(i) * 32'h400);
            check("ret_mis", {31'b0, mis0}, 32'd0);
        end
        check("ras_empty", {31'b0, empty0}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h1238, 26'h0, 16'h0);
        check("empty_ret_mis", {31'b0, mis0}, 32'd1);
        check("empty_stays", {31'b0, empty0}, 32'd1);

        // Mismatch with stall
        go_jr(32'h200);
        step(0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 26'h80, 16'h0);
        check("push204_pc", pc0, 32'h200);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h300, 26'h0, 16'h0);
        check("mm_pc", pc0, 32'h300);
        check("mm_mis", {31'b0, mis0}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 1, 1, 1, 1, 32'h500, 26'h7, 16'h9);
            check("stall_pc", pc0, 32'h300);
            check("stall_mis", {31'b0, mis0}, 32'd1);
        end
        idle();
        check("unstall_mis", {31'b0, mis0}, 32'd0);
        check("unstall_pc", pc0, 32'h304);

        // Width: ADDR_W=28 instance
        step(0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 26'h3FF_FFFF, 16'h0);
        check("w28_jump", {4'b0, pc1}, 32'h0FFF_FFFC);
        step(0, 1, 0, 1, 0, 0, 0, 0, 32'h0, 26'h0, 16'h0);
        check("w28_wrap", {4'b0, pc1}, 32'h0);

        // Reset in the middle of a stall
        stall = 1'b1;
        do_reset();
        stall = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        s, b, bne, z, j, l, r, rt;
            logic [31:0] ja;
            s   = ($urandom_range(0, 9) == 0);
            b   = ($urandom_range(0, 9) < 3);
            bne = $urandom_range(0, 1) == 1;
            z   = $urandom_range(0, 1) == 1;
            j   = ($urandom_range(0, 3) == 0);
            l   = ($urandom_range(0, 9) < 6);
            r   = ($urandom_range(0, 6) == 0);
            rt  = ($urandom_range(0, 9) < 6);
            ja  = $urandom & 32'hFFFF_FFFC;
            if (q0.size() > 0 && $urandom_range(0, 2) != 0) ja = q0[q0.size() - 1];
            step(s, b, bne, z, j, l, r, rt, ja, 26'($urandom), 16'($urandom));
            if (n % 997 == 500) do_reset();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
